loop_ctrl: RTL and testbench

//   Bracket/loop sequencer for the brainfuck core. Owns the return-address stack:

---
 rtl/loop_ctrl.sv | 123 ++++++++++++
 tb/tb_loop_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_ctrl.sv
// Bracket/loop sequencer: owns the return-address stack protocol, forward skip scan
// over zero-cell loops, and the jump-back pulse to the PC logic.
//
// state | meaning
// IDLE  | executing normally, accepts every instruction
// SKIP  | forward scan past a zero-cell loop, tracks bracket nesting
// JUMP  | one-cycle pc_load of the stacked loop-start address
// ERROR | stack/nest fault, frozen until reset
module loop_ctrl #(
  parameter int PC_W     = 16,
  parameter int STACK_AW = 9,
  parameter int NEST_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [1:0]          instr_op,
  input  logic [PC_W-1:0]     pc,
  input  logic                cell_zero,
  output logic                instr_ready,
  output logic                skip,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_target,
  output logic                stk_push,
  output logic                stk_pop,
  output logic [PC_W-1:0]     stk_din,
  input  logic [PC_W-1:0]     stk_top,
  output logic [STACK_AW:0]   depth,
  output logic                err,
  output logic [1:0]          err_code
);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_JUMP, S_ERROR} state_t;

  state_t              state_q, state_d;
  logic [STACK_AW:0]   depth_q, depth_d;
  logic [NEST_W-1:0]   nest_q, nest_d;
  logic [1:0]          err_code_q, err_code_d;

  logic accept, is_open, is_close, stk_full, stk_empty;

  assign accept    = instr_valid & instr_ready;
  assign is_open   = (instr_op == 2'b01);
  assign is_close  = (instr_op == 2'b10);
  assign stk_full  = depth_q[STACK_AW];
  assign stk_empty = (depth_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      nest_q     <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      nest_q     <= nest_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    nest_d     = nest_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_open) begin
          if (cell_zero) begin
            nest_d  = NEST_W'(1);
            state_d = S_SKIP;
          end else if (stk_full) begin
            err_code_d = 2'b01;
            state_d    = S_ERROR;
          end else begin
            depth_d = depth_q + (STACK_AW+1)'(1);
          end
        end else if (accept && is_close) begin
          if (stk_empty) begin
            err_code_d = 2'b10;
            state_d    = S_ERROR;
          end else if (cell_zero) begin
            depth_d = depth_q - (STACK_AW+1)'(1);
          end else begin
            state_d = S_JUMP;
          end
        end
      end
      S_SKIP: begin
        if (accept && is_open) begin
          if (&nest_q) begin
            err_code_d = 2'b11;
            state_d    = S_ERROR;
          end else begin
            nest_d = nest_q + NEST_W'(1);
          end
        end else if (accept && is_close) begin
          nest_d = nest_q - NEST_W'(1);
          if (nest_q == NEST_W'(1)) state_d = S_IDLE;
        end
      end
      S_JUMP:  state_d = S_IDLE;
      default: state_d = S_ERROR;
    endcase
  end

  // Push/pop are also gated by reset so the external stack never sees a strobe
  // while its pointer is being cleared.
  always_comb begin
    instr_ready = (state_q == S_IDLE) || (state_q == S_SKIP);
    skip        = (state_q == S_SKIP);
    pc_load     = (state_q == S_JUMP);
    pc_target   = (state_q == S_JUMP) ? stk_top : '0;
    err         = (state_q == S_ERROR);
    err_code    = err_code_q;
    depth       = depth_q;
    stk_push    = reset && (state_q == S_IDLE) && accept && is_open && !cell_zero && !stk_full;
    stk_pop     = reset && (state_q == S_IDLE) && accept && is_close && cell_zero && !stk_empty;
    stk_din     = stk_push ? (pc + PC_W'(1)) : '0;
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// Bench for loop_ctrl: directed bracket sequences, an external stack model, and a
// scoreboard that checks every push/pop/pc_load strobe against a queue of expected events.
module tb_loop_ctrl;
  localparam int PC_W     = 16;
  localparam int STACK_AW = 2;
  localparam int NEST_W   = 2;
  localparam int EV_PUSH  = 0;
  localparam int EV_POP   = 1;
  localparam int EV_LOAD  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                instr_valid;
  logic [1:0]          instr_op;
  logic [PC_W-1:0]     pc;
  logic                cell_zero;
  logic                instr_ready, skip, pc_load, stk_push, stk_pop, err;
  logic [PC_W-1:0]     pc_target, stk_din, stk_top;
  logic [STACK_AW:0]   depth;
  logic [1:0]          err_code;

  loop_ctrl #(.PC_W(PC_W), .STACK_AW(STACK_AW), .NEST_W(NEST_W)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_op(instr_op),
    .pc(pc), .cell_zero(cell_zero), .instr_ready(instr_ready), .skip(skip),
    .pc_load(pc_load), .pc_target(pc_target), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_top(stk_top), .depth(depth), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // external return-address stack: top is valid the cycle after a push/pop
  logic [PC_W-1:0] mem [0:15];
  int sp;
  always @(posedge clk or negedge reset) begin
    if (!reset) sp <= 0;
    else if (stk_push) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop) sp <= sp - 1;
  end
  always_comb stk_top = (sp > 0) ? mem[sp-1] : '0;

  typedef struct {int kind; logic [PC_W-1:0] val;} ev_t;
  ev_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic expect_ev(input int kind, input logic [PC_W-1:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && (stk_push || stk_pop || pc_load)) begin
      int kind;
      logic [PC_W-1:0] val;
      ev_t e;
      if (stk_push && stk_pop) chk("push_pop_exclusive", 32'(stk_pop), 32'd0);
      kind = pc_load ? EV_LOAD : (stk_push ? EV_PUSH : EV_POP);
      val  = pc_load ? pc_target : (stk_push ? stk_din : '0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got event kind %0d value %0h expected none", kind, val);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind", 32'(kind), 32'(e.kind));
        chk("sb_value", 32'(val), 32'(e.val));
      end
    end
  end

  // called at posedge+1; instruction is accepted at the next posedge
  task automatic send(input logic [1:0] op, input logic [PC_W-1:0] pcv, input logic cz);
    instr_valid = 1'b1;
    instr_op    = op;
    pc          = pcv;
    cell_zero   = cz;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_op    = 2'b00;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    chk({tag, "_skip"}, 32'(skip), 32'd0);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    #3 reset = 1'b1;
    cyc();
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr_op = 2'b00; pc = '0; cell_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_skip", 32'(skip), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_strobes", 32'({stk_push, stk_pop, pc_load}), 32'd0);
    reset = 1'b1;
    cyc();

    // loop taken back: push 6, then jump to 6
    expect_ev(EV_PUSH, 16'd6);
    send(2'b01, 16'd5, 1'b0);
    expect_ev(EV_LOAD, 16'd6);
    send(2'b10, 16'd9, 1'b0);
    chk("t1_jump_ready", 32'(instr_ready), 32'd0);
    chk("t1_pc_load", 32'(pc_load), 32'd1);
    chk("t1_pc_target", 32'(pc_target), 32'd6);
    cyc();
    chk("t1_depth", 32'(depth), 32'd1);
    chk("t1_idle_ready", 32'(instr_ready), 32'd1);

    // loop exit: pop
    expect_ev(EV_POP, 16'd0);
    send(2'b10, 16'd9, 1'b1);
    chk("t2_depth", 32'(depth), 32'd0);
    chk("t2_no_load", 32'(pc_load), 32'd0);

    // skip scan over nested zero loop
    send(2'b01, 16'd20, 1'b1);
    chk("t3_skip_on", 32'(skip), 32'd1);
    send(2'b01, 16'd21, 1'b0);
    send(2'b00, 16'd22, 1'b0);
    send(2'b10, 16'd23, 1'b0);
    chk("t3_skip_mid", 32'(skip), 32'd1);
    send(2'b10, 16'd24, 1'b1);
    chk("t3_skip_off", 32'(skip), 32'd0);
    chk("t3_ready", 32'(instr_ready), 32'd1);
    chk("t3_depth", 32'(depth), 32'd0);

    // nest counter overflow at 2**NEST_W-1
    send(2'b01, 16'd30, 1'b1);
    send(2'b01, 16'd31, 1'b0);
    send(2'b01, 16'd32, 1'b0);
    chk("nest_skip", 32'(skip), 32'd1);
    send(2'b01, 16'd33, 1'b0);
    chk("nest_err", 32'(err), 32'd1);
    chk("nest_code", 32'(err_code), 32'd3);
    chk("nest_ready", 32'(instr_ready), 32'd0);
    pulse_reset("nest_rst");

    // async reset in the middle of a skip scan
    send(2'b01, 16'd40, 1'b1);
    chk("mid_skip", 32'(skip), 32'd1);
    pulse_reset("skip_rst");

    // stack overflow at capacity 4
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_PUSH, 16'(11 + i));
      send(2'b01, 16'(10 + i), 1'b0);
    end
    chk("t4_depth_full", 32'(depth), 32'd4);
    send(2'b01, 16'd14, 1'b0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_code", 32'(err_code), 32'd1);
    chk("t4_ready", 32'(instr_ready), 32'd0);
    chk("t4_depth_hold", 32'(depth), 32'd4);
    cyc();
    chk("t4_sticky", 32'(err), 32'd1);
    pulse_reset("t4_rst");

    // underflow, both cell_zero values
    send(2'b10, 16'd50, 1'b1);
    chk("t5a_err", 32'(err), 32'd1);
    chk("t5a_code", 32'(err_code), 32'd2);
    pulse_reset("t5a_rst");
    send(2'b10, 16'd51, 1'b0);
    chk("t5b_err", 32'(err), 32'd1);
    chk("t5b_code", 32'(err_code), 32'd2);
    chk("t5b_no_load", 32'(pc_load), 32'd0);
    pulse_reset("t5b_rst");

    // back-to-back push then jump reads the fresh top
    expect_ev(EV_PUSH, 16'd4);
    send(2'b01, 16'd3, 1'b0);
    expect_ev(EV_LOAD, 16'd4);
    send(2'b10, 16'd7, 1'b0);
    chk("t6_pc_target", 32'(pc_target), 32'd4);
    cyc();
    cyc();
    chk("t6_depth", 32'(depth), 32'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
